// File: rtl/game_pkg.sv
// Shared encodings for the frame-loop sequencer: FSM state type and a layer-index width helper.
// The state type is also consumed by the datapath debug display.
`default_nettype none

package game_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_UPDATE    = 3'd2,
        ST_DRAW_REQ  = 3'd3,
        ST_DRAW_WAIT = 3'd4,
        ST_WAIT      = 3'd5,
        ST_END       = 3'd6
    } state_e;

    // Index width for n layers; a single layer still gets a 1-bit port.
    function automatic int layer_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_delay_counter.sv
// Down-counter for the inter-frame delay: synchronous load, hold, count-down stopping at zero,
// and a zero flag taken straight from the count register.
`default_nettype none

module frame_delay_counter #(
    parameter int CNT_W = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/game_loop_ctrl.sv
// Frame-loop sequencer: start handshake, update pulse, NUM_LAYERS draw passes, frame delay.
// Optional pause input in the delay phase is enabled by defining GAME_LOOP_PAUSE_EN.
`default_nettype none

module game_loop_ctrl
    import game_pkg::*;
#(
    parameter int NUM_LAYERS  = 4,
    parameter int FRAME_TICKS = 833333,
    parameter int CNT_W       = 20,
    parameter int FRAME_W     = 16,
    localparam int LAYER_W    = layer_width(NUM_LAYERS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               finish_game,
    input  logic               draw_done,
`ifdef GAME_LOOP_PAUSE_EN
    input  logic               pause,
`endif
    output logic               update,
    output logic               draw_start,
    output logic [LAYER_W-1:0] layer,
    output logic               drawing,
    output logic               game_over,
    output logic [FRAME_W-1:0] frame_count
);

    state_e             state_q, state_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic               hold_wait;
    logic               last_layer;

`ifdef GAME_LOOP_PAUSE_EN
    assign hold_wait = pause;
`else
    assign hold_wait = 1'b0;
`endif

    assign last_layer = (layer_q == LAYER_W'(NUM_LAYERS - 1));

    frame_delay_counter #(
        .CNT_W (CNT_W)
    ) u_delay (
        .clock      (clock),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(FRAME_TICKS - 1)),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            layer_q <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        frame_d  = frame_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!start) begin
                    state_d = ST_UPDATE;
                    frame_d = '0;
                end
            end
            ST_UPDATE: begin
                if (finish_game) begin
                    state_d = ST_END;
                end else begin
                    state_d = ST_DRAW_REQ;
                    layer_d = '0;
                end
            end
            ST_DRAW_REQ: begin
                state_d = ST_DRAW_WAIT;
            end
            ST_DRAW_WAIT: begin
                if (draw_done) begin
                    if (last_layer) begin
                        state_d  = ST_WAIT;
                        cnt_load = 1'b1;
                        frame_d  = frame_q + FRAME_W'(1);
                    end else begin
                        state_d = ST_DRAW_REQ;
                        layer_d = layer_q + LAYER_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                // Counter was loaded with FRAME_TICKS-1, so the zero cycle is the last WAIT cycle.
                if (!hold_wait) begin
                    if (cnt_zero) state_d = ST_UPDATE;
                    else          cnt_dec = 1'b1;
                end
            end
            ST_END: begin
                if (start) state_d = ST_ARM;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign update      = (state_q == ST_UPDATE);
    assign draw_start  = (state_q == ST_DRAW_REQ);
    assign drawing     = (state_q == ST_DRAW_REQ) || (state_q == ST_DRAW_WAIT);
    assign game_over   = (state_q == ST_END);
    assign layer       = layer_q;
    assign frame_count = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_game_loop_ctrl.sv
// Directed bench for game_loop_ctrl with NUM_LAYERS=4, FRAME_TICKS=5, FRAME_W=2.
`default_nettype none

module tb_game_loop_ctrl;

    localparam int NL = 4;
    localparam int FT = 5;
    localparam int CW = 3;
    localparam int FW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          finish_game;
    logic          draw_done;
    logic          pause;
    logic          update;
    logic          draw_start;
    logic [1:0]    layer;
    logic          drawing;
    logic          game_over;
    logic [FW-1:0] frame_count;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    game_loop_ctrl #(
        .NUM_LAYERS  (NL),
        .FRAME_TICKS (FT),
        .CNT_W       (CW),
        .FRAME_W     (FW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .finish_game (finish_game),
        .draw_done   (draw_done),
`ifdef GAME_LOOP_PAUSE_EN
        .pause       (pause),
`endif
        .update      (update),
        .draw_start  (draw_start),
        .layer       (layer),
        .drawing     (drawing),
        .game_over   (game_over),
        .frame_count (frame_count)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic upd, input logic ds,
                              input logic dr, input logic go);
        check({tag, ".update"},     32'(update),     32'(upd));
        check({tag, ".draw_start"}, 32'(draw_start), 32'(ds));
        check({tag, ".drawing"},    32'(drawing),    32'(dr));
        check({tag, ".game_over"},  32'(game_over),  32'(go));
    endtask

    // Entered just after the edge into DRAW_REQ; draw_done is returned 3 cycles after draw_start.
    task automatic draw_layer(input int l, input bit done_in_req);
        check_outs("draw_req", 1'b0, 1'b1, 1'b1, 1'b0);
        check("draw_req.layer", 32'(layer), 32'(l));
        draw_done = done_in_req;
        tick;
        draw_done = 1'b0;
        check_outs("draw_wait", 1'b0, 1'b0, 1'b1, 1'b0);
        check("draw_wait.layer", 32'(layer), 32'(l));
        tick;
        tick;
        draw_done = 1'b1;
        tick;
        draw_done = 1'b0;
    endtask

    // Entered in UPDATE; leaves in the next UPDATE.
    task automatic run_frame(input int fc, input bit noise);
        tick;
        finish_game = noise;
        for (int l = 0; l < NL; l++) draw_layer(l, l == 0);
        check_outs("wait_entry", 1'b0, 1'b0, 1'b0, 1'b0);
        check("wait_entry.frame_count", 32'(frame_count), 32'(fc));
        for (int i = 0; i < FT; i++) begin
            check("wait.update", 32'(update), 32'd0);
            tick;
        end
        check("frame_end.update", 32'(update), 32'd1);
        finish_game = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        finish_game = 1'b0;
        draw_done   = 1'b0;
        pause       = 1'b0;
        repeat (3) tick;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.layer", 32'(layer), 32'd0);
        check("reset.frame_count", 32'(frame_count), 32'd0);

        reset = 1'b1;
        tick;
        check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        start = 1'b1;
        repeat (5) begin
            tick;
            check("arm_hold.update", 32'(update), 32'd0);
        end
        start = 1'b0;
        tick;
        check("start_latency.update", 32'(update), 32'd1);
        check("start.frame_count", 32'(frame_count), 32'd0);

        run_frame(1, 1'b0);
        run_frame(2, 1'b1);
        run_frame(3, 1'b0);
        run_frame(0, 1'b0);
        run_frame(1, 1'b0);

        finish_game = 1'b1;
        tick;
        finish_game = 1'b0;
        check_outs("end", 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick;
        check_outs("end_hold", 1'b0, 1'b0, 1'b0, 1'b1);
        check("end_hold.frame_count", 32'(frame_count), 32'd1);

        start = 1'b1;
        tick;
        check_outs("restart_arm", 1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_arm.frame_count", 32'(frame_count), 32'd1);
        start = 1'b0;
        tick;
        check("restart.update", 32'(update), 32'd1);
        check("restart.frame_count", 32'(frame_count), 32'd0);

`ifdef GAME_LOOP_PAUSE_EN
        tick;
        for (int l = 0; l < NL; l++) draw_layer(l, 1'b0);
        pause = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 10) pause = 1'b0;
            check("pause.update", 32'(update), 32'd0);
            tick;
        end
        check("pause_end.update", 32'(update), 32'd1);
`endif

        tick;
        draw_layer(0, 1'b0);
        draw_layer(1, 1'b0);
        tick;
        check("pre_reset.layer", 32'(layer), 32'd2);
        check("pre_reset.drawing", 32'(drawing), 32'd1);
        reset = 1'b0;
        #1;
        check_outs("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        check_outs("reset_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_mid.layer", 32'(layer), 32'd0);
        check("reset_mid.frame_count", 32'(frame_count), 32'd0);
        reset = 1'b1;
        tick;
        check_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
